// File: rtl/object_pkg.sv
// Shared constants and types for the object blitter: object geometry,
// default colour keys and the sequencer state encoding.
package object_pkg;

    localparam int OBJ_W      = 16;
    localparam int OBJ_H      = 16;
    localparam int OBJ_ADDR_W = 8;
    localparam int OBJ_COL_W  = 4;   // low address bits select the column
    localparam int COLOR_W    = 24;

    // Address of the bottom-right pixel; reaching it ends the DRAW sweep.
    localparam logic [OBJ_ADDR_W-1:0] OBJ_LAST_ADDR = OBJ_ADDR_W'(OBJ_W * OBJ_H - 1);

    localparam logic [COLOR_W-1:0] DEF_TRANSP_COLOR = 24'h000000;
    localparam logic [COLOR_W-1:0] DEF_BG_COLOR     = 24'h000000;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FLUSH,
        DONE
    } blit_state_t;

endpackage

// File: rtl/object_blitter.sv
// Object blitter: sweeps the 256 addresses of a 16x16 object in a synchronous
// object memory and emits one VGA plot strobe per visible pixel, with colour
// key transparency, an erase mode and clipping at the right/bottom screen edge.
module object_blitter
    import object_pkg::*;
#(
    parameter int                 n            = 8,
    parameter bit                 TRANSP_EN    = 1'b1,
    parameter logic [COLOR_W-1:0] TRANSP_COLOR = DEF_TRANSP_COLOR,
    parameter logic [COLOR_W-1:0] BG_COLOR     = DEF_BG_COLOR
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  erase,
    input  logic [n-1:0]          XC,
    input  logic [n-2:0]          YC,
    output logic [OBJ_ADDR_W-1:0] mem_addr,
    input  logic [COLOR_W-1:0]    mem_data,
    output logic [n-1:0]          VGA_X,
    output logic [n-2:0]          VGA_Y,
    output logic [COLOR_W-1:0]    VGA_COLOR,
    output logic                  plot,
    output logic                  busy,
    output logic                  done
);

    blit_state_t                  state, state_next;
    logic [OBJ_ADDR_W-1:0]        cnt;

    // Pipeline stage that lines the pixel position up with the memory's
    // one-cycle read latency.
    logic                         v;
    logic [OBJ_COL_W-1:0]         px;
    logic [OBJ_ADDR_W-OBJ_COL_W-1:0] py;

    // Draw parameters captured at start so the caller may change them freely.
    logic [n-1:0]                 xc_lat;
    logic [n-2:0]                 yc_lat;
    logic                         erase_lat;

    // One extra bit on each sum catches pixels that fall off the screen.
    logic [n:0]                   sum_x;
    logic [n-1:0]                 sum_y;
    logic                         on_screen;
    logic                         key_hit;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the busy/done status outputs.
    // NOTE: every output of this block is given a default first; a path that
    // left one unassigned would make synthesis infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = DRAW;
            end
            DRAW: begin
                busy = 1'b1;
                if (cnt == OBJ_LAST_ADDR) state_next = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address counter, draw-parameter latch and pixel pipeline stage.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            v         <= 1'b0;
            px        <= '0;
            py        <= '0;
            xc_lat    <= '0;
            yc_lat    <= '0;
            erase_lat <= 1'b0;
        end else begin
            v <= (state == DRAW);
            if (state == IDLE && start) begin
                xc_lat    <= XC;
                yc_lat    <= YC;
                erase_lat <= erase;
                cnt       <= '0;
            end else if (state == DRAW) begin
                px  <= cnt[OBJ_COL_W-1:0];
                py  <= cnt[OBJ_ADDR_W-1:OBJ_COL_W];
                cnt <= cnt + 1'b1;   // wraps to 0 on the last address
            end
        end
    end

    assign mem_addr = cnt;

    assign sum_x     = {1'b0, xc_lat} + (n+1)'(px);
    assign sum_y     = {1'b0, yc_lat} + n'(py);
    assign on_screen = !sum_x[n] && !sum_y[n-1];
    assign key_hit   = TRANSP_EN && (mem_data == TRANSP_COLOR);

    assign plot      = v && on_screen && (erase_lat || !key_hit);
    assign VGA_COLOR = plot ? (erase_lat ? BG_COLOR : mem_data) : '0;
    assign VGA_X     = v ? sum_x[n-1:0] : '0;
    assign VGA_Y     = v ? sum_y[n-2:0] : '0;

endmodule

// File: tb/tb_object_blitter.sv
// Self-checking bench for object_blitter: random object memories, a
// row/column reference model of the drawn footprint, and scenario tasks.
module tb_object_blitter;

    localparam int          N  = 8;
    localparam logic [23:0] BG = 24'h00A5C3;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] c;
    } pix_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b0;
    logic        start    = 1'b0;
    logic        erase    = 1'b0;
    logic [7:0]  XC       = '0;
    logic [6:0]  YC       = '0;
    logic [7:0]  mem_addr;
    logic [23:0] mem_data;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [23:0] VGA_COLOR;
    logic        plot;
    logic        busy;
    logic        done;

    logic [23:0] mem [256];

    pix_t got[$];
    pix_t exp_q[$];
    int   done_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_busy, n_plot, first_plot, last_plot;

    object_blitter #(
        .n            (N),
        .TRANSP_EN    (1'b1),
        .TRANSP_COLOR (24'h000000),
        .BG_COLOR     (BG)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .erase     (erase),
        .XC        (XC),
        .YC        (YC),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Synchronous object memory: data appears one cycle after the address.
    always @(posedge CLOCK_50) mem_data <= mem[mem_addr];

    function automatic void fill_mem_nonzero();
        for (int i = 0; i < 256; i++) mem[i] = 24'($urandom_range(1, 24'hFFFFFF));
    endfunction

    function automatic void clear_stats();
        got.delete();
        done_q.delete();
        n_busy     = 0;
        n_plot     = 0;
        first_plot = -1;
        last_plot  = -1;
    endfunction

    // Record what the DUT shows during cycle k of a draw.
    function automatic void sample(input int k);
        if (busy) n_busy++;
        if (plot) begin
            got.push_back('{int'(VGA_X), int'(VGA_Y), VGA_COLOR});
            n_plot++;
            if (first_plot < 0) first_plot = k;
            last_plot = k;
        end
        if (done) done_q.push_back(k);
    endfunction

    // Reference: walk the object row by row and keep every pixel that lands
    // inside a 256x128 screen and is not the colour key (unless erasing).
    function automatic void build_expected(input int xc, input int yc, input bit er);
        exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int          x;
                int          y;
                logic [23:0] col;
                x   = xc + c;
                y   = yc + r;
                col = mem[r * 16 + c];
                if (x > 255 || y > 127) continue;
                if (!er && col == 24'h000000) continue;
                exp_q.push_back('{x, y, er ? BG : col});
            end
        end
    endfunction

    // Index of the first pixel that differs from the reference, -1 if all
    // agree, -2 if the pixel counts differ.
    function automatic int first_diff();
        if (got.size() != exp_q.size()) return -2;
        foreach (got[i]) begin
            if (got[i].x != exp_q[i].x || got[i].y != exp_q[i].y || got[i].c !== exp_q[i].c)
                return i;
        end
        return -1;
    endfunction

    // Issue one start pulse and watch a fixed 300-cycle window; optionally
    // poke start/XC/YC/erase while the draw is in progress.
    task automatic do_draw(input int xc, input int yc, input bit er, input bit disturb);
        clear_stats();
        @(negedge CLOCK_50);
        XC    = 8'(xc);
        YC    = 7'(yc);
        erase = er;
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLOCK_50);
            sample(k);
            if (k == 1) start = 1'b0;
            if (disturb && k == 50) begin
                start = 1'b1;
                XC    = XC ^ 8'h55;
                YC    = YC ^ 7'h2A;
                erase = ~er;
            end
            if (disturb && k == 51) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #3;
        checks++;
        if ({mem_addr, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%0h x=%0d y=%0d col=%0h plot=%0b busy=%0b done=%0b required all 0",
                     mem_addr, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done);
        end
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%0b plot=%0b required 0 0", busy, plot);
        end
    endtask

    task automatic test_basic_draw();
        fill_mem_nonzero();
        do_draw(72, 52, 1'b0, 1'b0);
        build_expected(72, 52, 1'b0);
        checks++;
        if (n_busy != 257) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d required 257", n_busy);
        end
        checks++;
        if (n_plot != 256) begin
            failures++;
            $display("FAIL basic_plot_count: got %0d required 256", n_plot);
        end
        checks++;
        if (first_plot != 2 || last_plot != 257) begin
            failures++;
            $display("FAIL basic_plot_window: got cycles %0d..%0d required 2..257", first_plot, last_plot);
        end
        checks++;
        if (got.size() == 0 || got[0].x != 72 || got[0].y != 52 || got[0].c !== mem[0]) begin
            failures++;
            $display("FAIL basic_first_pixel: got size=%0d required (72,52,%0h)", got.size(), mem[0]);
        end
        checks++;
        if (got.size() == 0 || got[$].x != 87 || got[$].y != 67 || got[$].c !== mem[255]) begin
            failures++;
            $display("FAIL basic_last_pixel: got size=%0d required (87,67,%0h)", got.size(), mem[255]);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 258) begin
            failures++;
            $display("FAIL basic_done: got %0d pulses first at %0d required 1 pulse at 258",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL basic_stream: got diff index %0d (plots %0d) required -1 (plots %0d)",
                     first_diff(), got.size(), exp_q.size());
        end
    endtask

    task automatic test_transparency();
        bit hit;
        fill_mem_nonzero();
        mem[17] = 24'h000000;
        do_draw(72, 52, 1'b0, 1'b0);
        build_expected(72, 52, 1'b0);
        checks++;
        if (n_plot != 255) begin
            failures++;
            $display("FAIL transp_plot_count: got %0d required 255", n_plot);
        end
        hit = 1'b0;
        foreach (got[i]) if (got[i].x == 73 && got[i].y == 53) hit = 1'b1;
        checks++;
        if (hit) begin
            failures++;
            $display("FAIL transp_key_pixel: got plot at (73,53) required none");
        end
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL transp_stream: got diff index %0d required -1", first_diff());
        end

        do_draw(72, 52, 1'b1, 1'b0);
        build_expected(72, 52, 1'b1);
        checks++;
        if (n_plot != 256) begin
            failures++;
            $display("FAIL erase_plot_count: got %0d required 256", n_plot);
        end
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL erase_stream: got diff index %0d required -1 (all colour %0h)", first_diff(), BG);
        end
    endtask

    task automatic test_clip();
        int min_x;
        fill_mem_nonzero();
        do_draw(250, 0, 1'b0, 1'b0);
        build_expected(250, 0, 1'b0);
        checks++;
        if (n_plot != 96) begin
            failures++;
            $display("FAIL clip_plot_count: got %0d required 96", n_plot);
        end
        min_x = 256;
        foreach (got[i]) if (got[i].x < min_x) min_x = got[i].x;
        checks++;
        if (min_x < 250) begin
            failures++;
            $display("FAIL clip_wrap: got min x %0d required >= 250", min_x);
        end
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL clip_stream: got diff index %0d required -1", first_diff());
        end
    endtask

    task automatic test_reset_mid_draw();
        fill_mem_nonzero();
        clear_stats();
        @(negedge CLOCK_50);
        XC    = 8'd40;
        YC    = 7'd30;
        erase = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLOCK_50);
            sample(k);
            if (k == 1) start = 1'b0;
        end
        checks++;
        if (plot !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_precondition: got plot=%0b busy=%0b required 1 1", plot, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 8'd0) begin
            failures++;
            $display("FAIL midreset_abort: got plot=%0b busy=%0b done=%0b addr=%0d required 0 0 0 0",
                     plot, busy, done, mem_addr);
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
        do_draw(10, 20, 1'b0, 1'b0);
        build_expected(10, 20, 1'b0);
        checks++;
        if (n_plot != 256 || done_q.size() != 1) begin
            failures++;
            $display("FAIL midreset_redraw: got plots=%0d dones=%0d required 256 1", n_plot, done_q.size());
        end
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL midreset_stream: got diff index %0d required -1", first_diff());
        end
    endtask

    task automatic test_ignore_while_busy();
        int xc;
        int yc;
        fill_mem_nonzero();
        xc = $urandom_range(0, 200);
        yc = $urandom_range(0, 100);
        do_draw(xc, yc, 1'b0, 1'b1);
        build_expected(xc, yc, 1'b0);
        checks++;
        if (done_q.size() != 1 || n_busy != 257) begin
            failures++;
            $display("FAIL ignore_single_draw: got dones=%0d busy=%0d required 1 257", done_q.size(), n_busy);
        end
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL ignore_latched_coords: got diff index %0d required -1 (origin %0d,%0d)",
                     first_diff(), xc, yc);
        end
    endtask

    task automatic test_back_to_back();
        int  plots_two;
        bit  seen;
        fill_mem_nonzero();
        clear_stats();
        plots_two = 0;
        @(negedge CLOCK_50);
        XC    = 8'd5;
        YC    = 7'd5;
        erase = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 520; k++) begin
            @(negedge CLOCK_50);
            sample(k);
            if (k == 518) plots_two = n_plot;
        end
        start = 1'b0;
        checks++;
        if (done_q.size() != 2 || done_q[0] != 258) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d pulses first at %0d required 2 first at 258",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        checks++;
        if (done_q.size() < 2 || done_q[1] - done_q[0] != 259) begin
            failures++;
            $display("FAIL b2b_done_spacing: got %0d required 259",
                     (done_q.size() >= 2) ? done_q[1] - done_q[0] : -1);
        end
        checks++;
        if (plots_two != 512) begin
            failures++;
            $display("FAIL b2b_plot_count: got %0d required 512", plots_two);
        end
        // Let the third draw, already under way, run to completion.
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge CLOCK_50);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_drain: got no done within 300 cycles required one");
        end
        repeat (2) @(negedge CLOCK_50);
    endtask

    initial begin
        test_reset();
        test_basic_draw();
        test_transparency();
        test_clip();
        test_reset_mid_draw();
        test_ignore_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/object_blitter.md
Name: object_blitter

Overview:
- Sequencer that draws one 16x16 object from the synchronous object memory (`object_mem`) onto the VGA pixel interface (VGA_X, VGA_Y, VGA_COLOR, plot) at a requested screen position.
- Sits between the top-level game/control logic, which issues start plus coordinates, and `object_mem`.
- Generates read addresses, aligns the 1-cycle memory latency, and pulses plot once per visible pixel.
- Supports transparency skipping and an erase mode that paints the object footprint with a background colour.

Parameters:
- n, 8, VGA X bitwidth (10 for 640x480, 9 for 320x240); Y width is n-1.
- TRANSP_EN, 1, when 1, pixels whose memory colour equals TRANSP_COLOR are not plotted.
- TRANSP_COLOR, 24'h000000, transparent key colour.
- BG_COLOR, 24'h000000, colour written in erase mode.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a draw; sampled only in IDLE.
- erase  in  1  sampled with start; 1 = paint BG_COLOR over the footprint.
- XC  in  n  object top-left X.
- YC  in  n-1  object top-left Y.
- mem_addr  out  8  object memory address {row[3:0], col[3:0]}.
- mem_data  in  24  object memory read data, valid 1 cycle after mem_addr.
- VGA_X  out  n  pixel column.
- VGA_Y  out  n-1  pixel row.
- VGA_COLOR  out  24  pixel colour.
- plot  out  1  pixel write strobe, one cycle per pixel.
- busy  out  1  high while drawing (DRAW, FLUSH).
- done  out  1  one-cycle pulse when the draw completes.

Behaviour:
- Reset (async): state IDLE, address counter 0, pipeline valid 0. Outputs: mem_addr 0, VGA_X 0, VGA_Y 0, VGA_COLOR 0, plot 0, busy 0, done 0.
- Reset asserted mid-draw aborts immediately. plot falls without waiting for a clock; no done pulse is issued.
- States: IDLE, DRAW, FLUSH, DONE.
  - IDLE: on start=1 at an edge, latch XC, YC, erase; counter <= 0; go to DRAW.
  - DRAW: mem_addr = counter; counter increments each edge. At the edge where counter==255, go to FLUSH (counter wraps to 0).
  - FLUSH: one cycle to emit the final pixel; then go to DONE.
  - DONE: done=1 for exactly one cycle; then go to IDLE.
- Start is ignored outside IDLE. start held high continuously yields back-to-back draws with one IDLE cycle between them.
- Latched XC/YC/erase are stable for the whole draw; input changes during busy have no effect.
- Pipeline: each edge in DRAW registers px=addr[3:0], py=addr[7:4], and v=1. In any other state v is registered as 0.
- Pixel for address a is presented in the cycle after a is on mem_addr. First plot is the cycle after entering DRAW+1 edge; 256 pixel slots total; last slot occurs in FLUSH.
- Coordinates:
  - VGA_X = XC_lat + px, computed at n+1 bits.
  - VGA_Y = YC_lat + py, computed at n bits.
  - A carry out of the output width marks the pixel off-screen; no wrap-around drawing.
- plot = v AND no X/Y overflow AND (erase_lat OR NOT (TRANSP_EN AND mem_data==TRANSP_COLOR)).
- VGA_COLOR = erase_lat ? BG_COLOR : mem_data when plot=1, otherwise 0.
- VGA_X and VGA_Y are the truncated sums while v=1, and 0 while v=0.
- busy = 1 in DRAW and FLUSH.
- Draw latency from start edge to done pulse: 258 cycles (done is high in the 258th cycle after the start edge).

Decomposition:
- Package `object_pkg`:
  - OBJ_W=16, OBJ_H=16, OBJ_ADDR_W=8.
  - Default TRANSP_COLOR and BG_COLOR constants.
  - State enum blit_state_t {IDLE, DRAW, FLUSH, DONE}.
- No sub-module inside the blitter. `object_mem` stays a sibling instance in the top level, wired to mem_addr and mem_data.

Test Plan:
- Reset, then start=1 with XC=72, YC=52, erase=0 and a memory with all pixels non-zero:
  - busy is high for 257 cycles.
  - plot is high in exactly 256 cycles, on consecutive cycles.
  - First pixel (72,52) carries the colour of addr 0; last pixel (87,67) carries the colour of addr 255.
  - done pulses once, 258 cycles after the start edge.
- Transparency: addr 17 = 24'h000000 with TRANSP_EN=1 → no plot at (73,53); 255 plots total. Same draw with erase=1 → 256 plots, all with VGA_COLOR=BG_COLOR.
- Clipping with n=8: XC=250, YC=0 → only columns 250..255 are plotted (6 per row, 96 total). No pixel at X 0..9.
- Reset asserted at cycle 100 of a draw → plot, busy and done are 0 immediately; mem_addr=0. A subsequent start draws a full 256-pixel object.
- start pulsed while busy, and XC changed mid-draw → ignored. Coordinates stay those latched at start; exactly one done pulse.
- start held high continuously → two full draws. Done pulses 259 cycles apart.
